mux4_scan_ctrl: RTL



---
 rtl/mux4_scan_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/mux4_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mux4_scan_ctrl
// Description : Steps a 4:1 mux select through channels 0..3, samples its
//               output after a settle dwell and emits a 4-bit snapshot frame.
// Revision    : 1.0 - initial release
// ============================================================================
module mux4_scan_ctrl #(
    parameter int SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       mux_out,
    output logic       s1,
    output logic       s0,
    output logic [3:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       busy,
    output logic       overrun,
    input  logic       ovr_clr
);

    localparam int              CW          = $clog2(SETTLE) + 1;
    localparam logic [CW-1:0]   c_CNT_LAST  = CW'(SETTLE - 1);
    localparam logic [CW-1:0]   c_CNT_ONE   = CW'(1);
    localparam logic [1:0]      c_CH_LAST   = 2'd3;

    localparam logic [1:0]      c_IDLE      = 2'd0;
    localparam logic [1:0]      c_SETTLE    = 2'd1;
    localparam logic [1:0]      c_PUSH      = 2'd2;

    logic [1:0]     r_state;
    logic [1:0]     w_state_nxt;
    logic [1:0]     r_ch;
    logic [CW-1:0]  r_cnt;
    logic [3:0]     r_shadow;
    logic [3:0]     r_data;
    logic           r_valid;
    logic           r_overrun;

    logic           w_sample;
    logic           w_load;
    logic           w_drop;

    // A completed frame may only replace the held one if it is being consumed
    assign w_sample = (r_state == c_SETTLE) && (r_cnt == c_CNT_LAST);
    assign w_load   = (r_state == c_PUSH) && (!r_valid || ready);
    assign w_drop   = (r_state == c_PUSH) && r_valid && !ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:   w_state_nxt = en ? c_SETTLE : c_IDLE;
            c_SETTLE: begin
                if (w_sample && (r_ch == c_CH_LAST)) begin
                    w_state_nxt = c_PUSH;
                end
            end
            c_PUSH:   w_state_nxt = en ? c_SETTLE : c_IDLE;
            default:  w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ch      <= 2'd0;
            r_cnt     <= '0;
            r_shadow  <= 4'b0000;
            r_data    <= 4'b0000;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (r_state == c_SETTLE) begin
                if (w_sample) begin
                    r_shadow[r_ch] <= mux_out;
                    r_cnt          <= '0;
                    // Channel 3 stays selected through PUSH, then wraps to 0
                    if (r_ch != c_CH_LAST) begin
                        r_ch <= r_ch + 2'd1;
                    end
                end else begin
                    r_cnt <= r_cnt + c_CNT_ONE;
                end
            end else begin
                r_cnt <= '0;
                r_ch  <= 2'd0;
            end

            if (w_load) begin
                r_data  <= r_shadow;
                r_valid <= 1'b1;
            end else if (r_valid && ready) begin
                r_valid <= 1'b0;
            end

            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (ovr_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    always_comb begin
        busy    = (r_state != c_IDLE);
        s1      = r_ch[1];
        s0      = r_ch[0];
        data    = r_data;
        valid   = r_valid;
        overrun = r_overrun;
    end

endmodule
`default_nettype wire
